// File: rtl/pipeline_ram_arbiter.sv
// Shares one single-port histogram RAM between an Avalon-MM slave and a register-driven command port.
// Ownership changes pass through DRAIN so every in-flight read returns to the port that issued it.
module pipeline_ram_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_cmd,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_wr,
    input  logic              cmd_rd,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [DATA_W-1:0] cmd_rdata,
    output logic              cmd_done,
    output logic              cmd_busy,
    input  logic [31:0]       av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_readdatavalid,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic              ram_rden,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        AV_OWN  = 2'd0,
        DRAIN   = 2'd1,
        CMD_OWN = 2'd2
    } own_e;

    own_e              state_q, state_d;
    logic [RD_LAT-1:0] pipe_v_q, pipe_v_d;
    logic [RD_LAT-1:0] pipe_src_q, pipe_src_d;
    logic              cmd_wr_q, cmd_rd_q;
    logic              wr_go_q, wr_go_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] cmd_rdata_q, cmd_rdata_d;

    logic              wr_edge, rd_edge, rd_issue, cmd_queued;
    logic              tail_v, tail_cmd, done_c;
    logic              wren_c, rden_c, src_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;
    logic [31:0]       av_word;
    logic              unused_av_hi;

    assign av_word      = av_address >> BYTE_SHIFT;
    assign unused_av_hi = ^av_word[31:ADDR_W];

    // Command edges only count while the command port owns the RAM; elsewhere they are dropped.
    assign wr_edge    = cmd_wr & ~cmd_wr_q & (state_q == CMD_OWN);
    assign rd_edge    = cmd_rd & ~cmd_rd_q & (state_q == CMD_OWN);
    assign rd_issue   = rd_pend_q & ~wr_go_q & (state_q == CMD_OWN);
    assign cmd_queued = wr_go_q | rd_pend_q | wr_edge | rd_edge;
    assign tail_v     = pipe_v_q[RD_LAT-1];
    assign tail_cmd   = pipe_src_q[RD_LAT-1];
    assign done_c     = tail_v & tail_cmd;

    always_comb begin
        wren_c  = 1'b0;
        rden_c  = 1'b0;
        src_c   = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        case (state_q)
            AV_OWN: begin
                addr_c  = av_word[ADDR_W-1:0];
                wren_c  = av_write;
                rden_c  = av_read & ~av_write;
                wdata_c = av_writedata;
            end
            CMD_OWN: begin
                wren_c  = wr_go_q;
                rden_c  = rd_issue;
                src_c   = 1'b1;
                addr_c  = wr_go_q ? wr_addr_q : rd_addr_q;
                wdata_c = wr_data_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        pipe_v_d      = '0;
        pipe_src_d    = '0;
        pipe_v_d[0]   = rden_c;
        pipe_src_d[0] = src_c;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_v_d[i]   = pipe_v_q[i-1];
            pipe_src_d[i] = pipe_src_q[i-1];
        end

        wr_go_d   = wr_edge;
        wr_addr_d = wr_edge ? cmd_addr : wr_addr_q;
        wr_data_d = wr_edge ? cmd_wdata : wr_data_q;
        // A single pending-read slot: a read edge arriving while it is occupied is lost.
        rd_pend_d = rd_pend_q ? ~rd_issue : rd_edge;
        rd_addr_d = (~rd_pend_q & rd_edge) ? cmd_addr : rd_addr_q;

        cmd_rdata_d = done_c ? ram_rdata : cmd_rdata_q;

        state_d = state_q;
        case (state_q)
            AV_OWN:  if (sel_cmd) state_d = DRAIN;
            CMD_OWN: if (!sel_cmd && !cmd_queued) state_d = DRAIN;
            DRAIN:   if (pipe_v_q == '0) state_d = sel_cmd ? CMD_OWN : AV_OWN;
            default: state_d = AV_OWN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= AV_OWN;
            pipe_v_q    <= '0;
            pipe_src_q  <= '0;
            cmd_wr_q    <= 1'b0;
            cmd_rd_q    <= 1'b0;
            wr_go_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_data_q   <= '0;
            cmd_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pipe_v_q    <= pipe_v_d;
            pipe_src_q  <= pipe_src_d;
            cmd_wr_q    <= cmd_wr;
            cmd_rd_q    <= cmd_rd;
            wr_go_q     <= wr_go_d;
            rd_pend_q   <= rd_pend_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_data_q   <= wr_data_d;
            cmd_rdata_q <= cmd_rdata_d;
        end
    end

    assign ram_wren         = ~rst & wren_c;
    assign ram_rden         = ~rst & rden_c;
    assign ram_addr         = rst ? '0 : addr_c;
    assign ram_wdata        = rst ? '0 : wdata_c;
    assign av_waitrequest   = rst | (state_q != AV_OWN);
    assign av_readdatavalid = ~rst & tail_v & ~tail_cmd;
    assign av_readdata      = av_readdatavalid ? ram_rdata : '0;
    assign cmd_done         = ~rst & done_c;
    assign cmd_rdata        = rst ? '0 : (done_c ? ram_rdata : cmd_rdata_q);
    assign cmd_busy         = ~rst & ((|(pipe_v_q & pipe_src_q)) | rd_pend_q);
endmodule

// File: tb/tb_pipeline_ram_arbiter.sv
// Directed bench for pipeline_ram_arbiter with a 2-cycle RAM model and queue-based return checking.
module tb_pipeline_ram_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic sel_cmd;
  logic [ADDR_W-1:0] cmd_addr;
  logic cmd_wr, cmd_rd;
  logic [DATA_W-1:0] cmd_wdata, cmd_rdata;
  logic cmd_done, cmd_busy;
  logic [31:0] av_address;
  logic av_read, av_write;
  logic [DATA_W-1:0] av_writedata, av_readdata;
  logic av_readdatavalid, av_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_wren, ram_rden;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] av_exp_q[$];
  logic [DATA_W-1:0] cmd_exp_q[$];

  // Handshake: a read return is presented for exactly one cycle by av_readdatavalid or cmd_done.
  pipeline_ram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .sel_cmd(sel_cmd),
    .cmd_addr(cmd_addr), .cmd_wr(cmd_wr), .cmd_rd(cmd_rd), .cmd_wdata(cmd_wdata),
    .cmd_rdata(cmd_rdata), .cmd_done(cmd_done), .cmd_busy(cmd_busy),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_readdatavalid(av_readdatavalid), .av_waitrequest(av_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_rden(ram_rden),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM model: unwritten words read as 0xC0DE0000 | address, two-cycle read latency
  logic [DATA_W-1:0] mem [32];
  logic [31:0] written;
  logic [DATA_W-1:0] s1, s2;
  always @(posedge clk) begin
    if (rst) written <= '0;
    else if (ram_wren) written[ram_addr] <= 1'b1;
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    s1 <= written[ram_addr] ? mem[ram_addr] : (32'hC0DE_0000 | 32'(ram_addr));
    s2 <= s1;
  end
  assign ram_rdata = s2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (av_readdatavalid) begin
      if (av_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL av_unexpected: got readdatavalid data 0x%08h expected none", av_readdata);
      end else chk("av_readdata", av_readdata, av_exp_q.pop_front());
    end
    if (cmd_done) begin
      if (cmd_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL cmd_unexpected: got cmd_done data 0x%08h expected none", cmd_rdata);
      end else chk("cmd_rdata", cmd_rdata, cmd_exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wr_cnt;
    int rd_cnt;
    int vld_cnt;
    bit back;
    rst = 1; sel_cmd = 0; cmd_addr = '0; cmd_wr = 0; cmd_rd = 0; cmd_wdata = '0;
    av_address = '0; av_read = 0; av_write = 0; av_writedata = '0;

    repeat (3) cyc();
    mid();
    chk("rst_waitreq", 32'(av_waitrequest), 1);
    chk("rst_wren", 32'(ram_wren), 0);
    chk("rst_rdvalid", 32'(av_readdatavalid), 0);
    cyc(); rst = 0;
    mid();
    chk("idle_waitreq", 32'(av_waitrequest), 0);
    chk("idle_busy", 32'(cmd_busy), 0);
    chk("idle_cmd_rdata", cmd_rdata, 0);

    // Avalon write then read of word 3
    cyc(); av_write = 1; av_address = 32'h0C; av_writedata = 32'hA5A5_A5A5;
    mid();
    chk("av_wr_wren", 32'(ram_wren), 1);
    chk("av_wr_addr", 32'(ram_addr), 3);
    chk("av_wr_wdata", ram_wdata, 32'hA5A5_A5A5);
    chk("av_wr_rden", 32'(ram_rden), 0);
    cyc(); av_write = 0; av_read = 1; av_exp_q.push_back(32'hA5A5_A5A5);
    mid();
    chk("av_rd_rden", 32'(ram_rden), 1);
    chk("av_rd_addr", 32'(ram_addr), 3);
    cyc(); av_read = 0;
    mid();
    chk("av_rd_lat_early", 32'(av_readdatavalid), 0);
    cyc();
    mid();
    chk("av_rd_lat", 32'(av_readdatavalid), 1);

    // read+write together: write wins; upper address bits ignored
    cyc(); av_write = 1; av_read = 1; av_address = 32'h1000_0084; av_writedata = 32'hDEAD_BEEF;
    mid();
    chk("both_wren", 32'(ram_wren), 1);
    chk("both_rden", 32'(ram_rden), 0);
    chk("addr_wrap", 32'(ram_addr), 1);
    cyc(); av_write = 0; av_read = 0;

    // three back-to-back reads, ownership request on the third
    cyc(); av_read = 1; av_address = 32'h10; av_exp_q.push_back(32'hC0DE_0004);
    cyc(); av_address = 32'h14; av_exp_q.push_back(32'hC0DE_0005);
    cyc(); av_address = 32'h18; av_exp_q.push_back(32'hC0DE_0006); sel_cmd = 1;
    mid();
    chk("sel_same_cycle_waitreq", 32'(av_waitrequest), 0);
    cyc(); av_read = 0;
    mid();
    chk("drain_waitreq", 32'(av_waitrequest), 1);
    chk("drain_no_rden", 32'(ram_rden), 0);
    cyc();
    mid();
    chk("third_return", 32'(av_readdatavalid), 1);
    cyc(); cmd_rd = 1; cmd_addr = 5'd9;
    mid();
    chk("all_returned", 32'(av_exp_q.size()), 0);
    cyc(); cmd_rd = 0;
    mid();
    chk("drain_edge_dropped", 32'(ram_rden), 0);
    cyc(); cmd_rd = 1; cmd_exp_q.push_back(32'hC0DE_0009);
    cyc(); cmd_rd = 0;
    mid();
    chk("cmd_own_rden", 32'(ram_rden), 1);
    chk("cmd_own_addr", 32'(ram_addr), 9);
    repeat (3) cyc();

    // held write level produces exactly one RAM write
    cyc(); cmd_wr = 1; cmd_addr = 5'd7; cmd_wdata = 32'h1234;
    mid();
    chk("cmdwr_t0", 32'(ram_wren), 0);
    wr_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      mid();
      if (ram_wren) wr_cnt++;
      if (i == 1) begin
        chk("cmdwr_wren", 32'(ram_wren), 1);
        chk("cmdwr_addr", 32'(ram_addr), 7);
        chk("cmdwr_wdata", ram_wdata, 32'h1234);
      end
    end
    chk("cmdwr_once", 32'(wr_cnt), 1);
    cyc(); cmd_wr = 0;

    // simultaneous write and read edges at word 2
    cyc(); cmd_wr = 1; cmd_rd = 1; cmd_addr = 5'd2; cmd_wdata = 32'h5555;
    cmd_exp_q.push_back(32'h5555);
    cyc(); cmd_wr = 0; cmd_rd = 0;
    mid();
    chk("dual_t1_wren", 32'(ram_wren), 1);
    chk("dual_t1_rden", 32'(ram_rden), 0);
    chk("dual_t1_addr", 32'(ram_addr), 2);
    chk("dual_t1_busy", 32'(cmd_busy), 1);
    cyc();
    mid();
    chk("dual_t2_rden", 32'(ram_rden), 1);
    chk("dual_t2_wren", 32'(ram_wren), 0);
    chk("dual_t2_busy", 32'(cmd_busy), 1);
    cyc();
    mid();
    chk("dual_t3_busy", 32'(cmd_busy), 1);
    chk("dual_t3_done", 32'(cmd_done), 0);
    cyc();
    mid();
    chk("dual_t4_done", 32'(cmd_done), 1);

    // back to Avalon; command read edge there is dropped
    cyc(); sel_cmd = 0;
    back = 0;
    for (int i = 0; i < 10 && !back; i++) begin
      mid();
      if (!av_waitrequest) back = 1;
      else cyc();
    end
    chk("back_to_av", 32'(back), 1);
    cyc(); cmd_rd = 1; cmd_addr = 5'd4;
    rd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      mid();
      if (ram_rden) rd_cnt++;
      cyc();
    end
    cmd_rd = 0;
    chk("av_own_cmd_rd_dropped", 32'(rd_cnt), 0);

    // reset with two Avalon reads in flight
    cyc(); av_read = 1; av_address = 32'h0;
    cyc(); av_address = 32'h4;
    cyc(); av_read = 0; rst = 1;
    mid();
    chk("midrst_waitreq", 32'(av_waitrequest), 1);
    chk("midrst_rdvalid", 32'(av_readdatavalid), 0);
    cyc(); rst = 0;
    vld_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      mid();
      if (av_readdatavalid) vld_cnt++;
      cyc();
    end
    chk("post_rst_no_rdvalid", 32'(vld_cnt), 0);

    repeat (3) cyc();
    chk("av_queue_empty", 32'(av_exp_q.size()), 0);
    chk("cmd_queue_empty", 32'(cmd_exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
